// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mips_mem_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned STARVE_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive fetch losses; flags when fetch must win.
module arb_starve_counter
    import mips_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic starved
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (clr) begin
            starve_cnt <= '0;
        end else if (inc && (starve_cnt != '1)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign starved = (starve_cnt >= LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between fetch (IF) and load/store (D).
// Data has priority; the starve counter forces a fetch grant after STARVE_LIMIT losses.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [WORD_W-1:0]     if_addr,
    output logic [WORD_W-1:0]     if_rdata,
    output logic                  if_valid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [WORD_W-1:0]     d_addr,
    input  logic [WORD_W-1:0]     d_wdata,
    output logic [WORD_W-1:0]     d_rdata,
    output logic                  d_valid,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_W-1:0]     mem_wdata,
    input  logic [WORD_W-1:0]     mem_rdata
);

    localparam logic [2:0] WAIT_LOAD = 3'(MEM_LATENCY - 1);

    arb_state_t            state, next_state;
    owner_t                owner;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_we;
    logic [WORD_W-1:0]     lat_wdata;
    logic [2:0]            wait_cnt;
    logic                  grant_d, grant_if, if_starved;
    logic                  unused_addr_bits;

    // Byte offset and bits beyond the memory size are dropped silently.
    assign unused_addr_bits = ^{if_addr[1:0], if_addr[WORD_W-1:ADDR_WIDTH+2],
                                d_addr[1:0],  d_addr[WORD_W-1:ADDR_WIDTH+2]};

    always_comb begin
        grant_d  = (state == IDLE) && d_req && (!if_req || !if_starved);
        grant_if = (state == IDLE) && if_req && !grant_d;
    end

    arb_starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clock   (clock),
        .reset   (reset),
        .inc     (grant_d && if_req),
        .clr     (grant_if),
        .starved (if_starved)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (grant_d || grant_if) next_state = ISSUE;
            ISSUE: next_state = (MEM_LATENCY > 1) ? WAIT : DONE;
            // The decrement in this cycle brings the counter to zero.
            WAIT:  if (wait_cnt <= 3'd1) next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        if (state == ISSUE) begin
            mem_en = 1'b1;
            mem_we = lat_we;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner     <= OWNER_IF;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            wait_cnt  <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        owner     <= OWNER_D;
                        lat_addr  <= d_addr[ADDR_WIDTH+1:2];
                        lat_we    <= d_we;
                        lat_wdata <= d_wdata;
                    end else if (grant_if) begin
                        owner    <= OWNER_IF;
                        lat_addr <= if_addr[ADDR_WIDTH+1:2];
                        lat_we   <= 1'b0;
                    end
                end
                ISSUE: wait_cnt <= WAIT_LOAD;
                WAIT:  wait_cnt <= wait_cnt - 3'd1;
                DONE: begin
                    if (owner == OWNER_D) begin
                        d_valid <= 1'b1;
                        if (!lat_we) d_rdata <= mem_rdata;
                    end else begin
                        if_valid <= 1'b1;
                        if_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner cases and a random
// run against an event-schedule reference model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int L0  = 1;
    localparam int SL0 = 4;
    localparam int L3  = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // DUT u0: default parameters
    logic        a_if_req = 0, a_d_req = 0, a_d_we = 0;
    logic [31:0] a_if_addr = 0, a_d_addr = 0, a_d_wdata = 0;
    logic [31:0] a_if_rdata, a_d_rdata, a_mem_wdata, a_mem_rdata;
    logic        a_if_valid, a_d_valid, a_mem_en, a_mem_we;
    logic [7:0]  a_mem_addr;

    // DUT u3: three-cycle memory latency
    logic        b_if_req = 0, b_d_req = 0, b_d_we = 0;
    logic [31:0] b_if_addr = 0, b_d_addr = 0, b_d_wdata = 0;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
    logic        b_if_valid, b_d_valid, b_mem_en, b_mem_we;
    logic [7:0]  b_mem_addr;

    mem_port_arbiter #(.ADDR_WIDTH(8), .MEM_LATENCY(L0), .STARVE_LIMIT(SL0)) u0 (
        .clock(clock), .reset(reset),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_valid(a_if_valid),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_rdata(a_d_rdata), .d_valid(a_d_valid),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    mem_port_arbiter #(.ADDR_WIDTH(8), .MEM_LATENCY(L3), .STARVE_LIMIT(SL0)) u3 (
        .clock(clock), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_valid(b_if_valid),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_rdata(b_d_rdata), .d_valid(b_d_valid),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // Memory arrays; read data appears L cycles after mem_en, garbage otherwise
    logic [31:0] a_mem [256];
    logic [31:0] b_mem [256];
    logic [31:0] ref_mem [256];
    logic [31:0] a_pipe;
    logic [31:0] b_pipe [3];

    always @(posedge clock) begin
        a_pipe <= a_mem_en ? a_mem[a_mem_addr] : 32'hBAD0_BAD0;
        if (a_mem_en && a_mem_we) a_mem[a_mem_addr] = a_mem_wdata;
    end
    assign a_mem_rdata = a_pipe;

    always @(posedge clock) begin
        b_pipe[0] <= b_mem_en ? b_mem[b_mem_addr] : 32'hBAD0_BAD0;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
        if (b_mem_en && b_mem_we) b_mem[b_mem_addr] = b_mem_wdata;
    end
    assign b_mem_rdata = b_pipe[2];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, ".a_mem_en"},    32'(a_mem_en),   0);
        check({tag, ".a_mem_we"},    32'(a_mem_we),   0);
        check({tag, ".a_mem_addr"},  32'(a_mem_addr), 0);
        check({tag, ".a_mem_wdata"}, a_mem_wdata,     0);
        check({tag, ".a_if_valid"},  32'(a_if_valid), 0);
        check({tag, ".a_d_valid"},   32'(a_d_valid),  0);
        check({tag, ".a_if_rdata"},  a_if_rdata,      0);
        check({tag, ".a_d_rdata"},   a_d_rdata,       0);
    endtask

    task automatic check_b_zero(input string tag);
        check({tag, ".b_mem_en"},    32'(b_mem_en),   0);
        check({tag, ".b_mem_we"},    32'(b_mem_we),   0);
        check({tag, ".b_mem_addr"},  32'(b_mem_addr), 0);
        check({tag, ".b_mem_wdata"}, b_mem_wdata,     0);
        check({tag, ".b_if_valid"},  32'(b_if_valid), 0);
        check({tag, ".b_d_valid"},   32'(b_d_valid),  0);
        check({tag, ".b_if_rdata"},  b_if_rdata,      0);
        check({tag, ".b_d_rdata"},   b_d_rdata,       0);
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  exp_addr;
        logic [31:0] exp_rdata;   // owner's rdata after completion
    } vec_t;

    vec_t vecs [9];

    // One isolated access on u0: grant at cycle 0, mem_en at 1, valid at L0+2.
    task automatic run_vec(input vec_t v, input int idx);
        int  cyc = 0;
        int  en_cnt = 0;
        bit  done = 0;
        string p = $sformatf("vec%0d", idx);
        if (v.is_d) begin
            a_d_req = 1; a_d_we = v.we; a_d_addr = v.addr; a_d_wdata = v.wdata;
        end else begin
            a_if_req = 1; a_if_addr = v.addr;
        end
        while (!done && cyc < 20) begin
            @(posedge clock); #1; cyc++;
            if (a_mem_en) begin
                en_cnt++;
                check({p, ".en_cycle"}, cyc, 1);
                check({p, ".mem_addr"}, 32'(a_mem_addr), 32'(v.exp_addr));
                check({p, ".mem_we"},   32'(a_mem_we),   32'(v.we));
                if (v.we) check({p, ".mem_wdata"}, a_mem_wdata, v.wdata);
            end
            if (a_if_valid || a_d_valid) begin
                done = 1;
                check({p, ".valid_cycle"}, cyc, L0 + 2);
                check({p, ".valid_owner"}, 32'({a_if_valid, a_d_valid}), v.is_d ? 1 : 2);
                check({p, ".rdata"}, v.is_d ? a_d_rdata : a_if_rdata, v.exp_rdata);
                a_if_req = 0; a_d_req = 0;
            end
        end
        check({p, ".completed"}, 32'(done), 1);
        check({p, ".en_count"}, en_cnt, 1);
        if (v.we) ref_mem[v.exp_addr] = v.wdata;
    endtask

    initial begin
        int n, ifcnt, cyc, en_cnt, en_cyc, vcyc, vcnt;
        // random-phase model state
        int t, en_t, vd_t, free_t, streak;
        logic [7:0]  en_addr, w;
        logic        en_we, vd_d, gd, pend_if, pend_d;
        logic [31:0] en_wdata, vd_data, last_d, r, addr_m;

        for (int i = 0; i < 256; i++) begin
            a_mem[i]   = 32'hA5A5_0000 | 32'(i);
            b_mem[i]   = 32'hA5A5_0000 | 32'(i);
            ref_mem[i] = 32'hA5A5_0000 | 32'(i);
        end
        a_mem[4]   = 32'h2402_0005;
        ref_mem[4] = 32'h2402_0005;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          8'h04, 32'h2402_0005};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF,  8'h10, 32'h0000_0000};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,          8'h10, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 1'b0, 32'hFFFF_F013, 32'h0,          8'h04, 32'h2402_0005};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_03FC, 32'h1234_5678,  8'hFF, 32'hDEAD_BEEF};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_03FF, 32'h0,          8'hFF, 32'h1234_5678};
        vecs[6] = '{1'b1, 1'b0, 32'hABCD_0041, 32'h0,          8'h10, 32'hDEAD_BEEF};
        vecs[7] = '{1'b1, 1'b1, 32'h0000_0008, 32'hCAFE_F00D,  8'h02, 32'hDEAD_BEEF};
        vecs[8] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,          8'h02, 32'hCAFE_F00D};

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_a_zero("reset");
        check_b_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Both requesters held: D wins SL0 times, then IF is forced through
        reset_pulse();
        a_if_req = 1; a_if_addr = 32'h10;
        a_d_req = 1; a_d_we = 0; a_d_addr = 32'h40;
        n = 0; ifcnt = 0; cyc = 0;
        while (n < 10 && cyc < 60) begin
            @(posedge clock); #1; cyc++;
            if (a_if_valid || a_d_valid) begin
                check($sformatf("prio%0d.owner", n), 32'({a_if_valid, a_d_valid}),
                      ((n % (SL0 + 1)) == SL0) ? 2 : 1);
                check($sformatf("prio%0d.rdata", n), a_if_valid ? a_if_rdata : a_d_rdata,
                      a_if_valid ? 32'h2402_0005 : 32'hDEAD_BEEF);
                ifcnt += int'(a_if_valid);
                n++;
            end
        end
        a_if_req = 0; a_d_req = 0;
        check("prio.accesses", n, 10);
        check("prio.if_valid_count", ifcnt, 2);

        // Latency sweep on u3
        b_d_req = 1; b_d_we = 0; b_d_addr = 32'h40; b_d_wdata = 32'h1111_2222;
        cyc = 0; en_cnt = 0; en_cyc = -1; vcyc = -1;
        while (vcyc < 0 && cyc < 12) begin
            @(posedge clock); #1; cyc++;
            if (b_mem_en) begin
                en_cnt++; en_cyc = cyc;
                check("lat3.mem_addr", 32'(b_mem_addr), 32'h10);
            end
            if (b_d_valid) begin
                vcyc = cyc;
                b_d_req = 0;
                check("lat3.d_rdata", b_d_rdata, 32'hA5A5_0010);
            end
        end
        b_d_req = 0;
        check("lat3.en_cycle", en_cyc, 1);
        check("lat3.en_count", en_cnt, 1);
        check("lat3.valid_cycle", vcyc, L3 + 2);

        // Reset while u3 sits in WAIT
        b_if_req = 1; b_if_addr = 32'h14;
        @(posedge clock); #1;
        check("rstmid.en_c1", 32'(b_mem_en), 1);
        @(posedge clock); #1;
        check("rstmid.en_c2", 32'(b_mem_en), 0);
        reset = 1'b1; b_if_req = 0;
        @(posedge clock); #1;
        check_b_zero("rstmid");
        reset = 1'b0;
        vcnt = 0;
        repeat (6) begin
            @(posedge clock); #1;
            vcnt += int'(b_if_valid) + int'(b_d_valid) + int'(b_mem_en);
        end
        check("rstmid.no_activity", vcnt, 0);
        b_if_req = 1; b_if_addr = 32'h14;
        cyc = 0; en_cyc = -1; vcyc = -1;
        while (vcyc < 0 && cyc < 12) begin
            @(posedge clock); #1; cyc++;
            if (b_mem_en) en_cyc = cyc;
            if (b_if_valid) begin
                vcyc = cyc;
                b_if_req = 0;
                check("rstmid.after_rdata", b_if_rdata, 32'hA5A5_0005);
            end
        end
        b_if_req = 0;
        check("rstmid.after_en_cycle", en_cyc, 1);
        check("rstmid.after_valid_cycle", vcyc, L3 + 2);

        // Random requesters on u0 against a schedule model
        reset_pulse();
        t = 0; en_t = -10; vd_t = -10; free_t = 0; streak = 0;
        last_d = 0; pend_if = 0; pend_d = 0; vd_d = 0; vd_data = 0;
        en_addr = 0; en_we = 0; en_wdata = 0;
        for (int k = 0; k < 1500; k++) begin
            check("rnd.mem_en", 32'(a_mem_en), 32'(t == en_t));
            if (t == en_t) begin
                check("rnd.mem_addr", 32'(a_mem_addr), 32'(en_addr));
                check("rnd.mem_we", 32'(a_mem_we), 32'(en_we));
                if (en_we) check("rnd.mem_wdata", a_mem_wdata, en_wdata);
            end
            check("rnd.if_valid", 32'(a_if_valid), 32'(t == vd_t && !vd_d));
            check("rnd.d_valid",  32'(a_d_valid),  32'(t == vd_t && vd_d));
            if (t == vd_t) begin
                if (vd_d) begin
                    check("rnd.d_rdata", a_d_rdata, vd_data);
                    pend_d = 0; a_d_req = 0;
                end else begin
                    check("rnd.if_rdata", a_if_rdata, vd_data);
                    pend_if = 0; a_if_req = 0;
                end
            end
            if (!pend_if && $urandom_range(0, 2) == 0) begin
                r = $urandom; r[9:2] = 8'($urandom_range(0, 15));
                pend_if = 1; a_if_req = 1; a_if_addr = r;
            end
            if (!pend_d && $urandom_range(0, 2) == 0) begin
                r = $urandom; r[9:2] = 8'($urandom_range(0, 15));
                pend_d = 1; a_d_req = 1; a_d_addr = r;
                a_d_we = 1'($urandom_range(0, 1)); a_d_wdata = $urandom;
            end
            if (t >= free_t && (a_if_req || a_d_req)) begin
                gd = a_d_req && (!a_if_req || streak < SL0);
                if (gd && a_if_req) streak = (streak < 15) ? streak + 1 : 15;
                else if (!gd) streak = 0;
                addr_m = gd ? a_d_addr : a_if_addr;
                w = addr_m[9:2];
                en_t = t + 1; en_addr = w;
                en_we = gd && a_d_we; en_wdata = a_d_wdata;
                vd_t = t + L0 + 2; free_t = vd_t; vd_d = gd;
                if (en_we) begin
                    ref_mem[w] = a_d_wdata;
                    vd_data = last_d;
                end else begin
                    vd_data = ref_mem[w];
                    if (gd) last_d = vd_data;
                end
            end
            @(posedge clock); #1; t++;
        end
        a_if_req = 0; a_d_req = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
